// File: rtl/kmap_bist_pkg.sv
// Shared types and constants for the K-map BIST checker.
package kmap_bist_pkg;

  localparam logic [15:0] KMAP_SOP_TRUTH = 16'hE3AA;  // F = QS + P'R'S + PQR + P'RS + PQ'R'
  localparam int unsigned IDX_W = 4;
  localparam int unsigned ERR_W = 5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } bist_state_e;

endpackage

// File: rtl/kmap_bist_checker_if.sv
// Control, status and DUT-stimulus bundle between a host and the BIST checker.
interface kmap_bist_checker_if;
  import kmap_bist_pkg::*;

  logic             start;
  logic             dut_p;
  logic             dut_q;
  logic             dut_r;
  logic             dut_s;
  logic             dut_f;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid;
  logic [IDX_W-1:0] first_fail_idx;
  logic [15:0]      captured;

  modport master (
    output start, dut_f,
    input  dut_p, dut_q, dut_r, dut_s, busy, done, pass, err_count,
           first_fail_valid, first_fail_idx, captured
  );

  modport slave (
    input  start, dut_f,
    output dut_p, dut_q, dut_r, dut_s, busy, done, pass, err_count,
           first_fail_valid, first_fail_idx, captured
  );

endinterface

// File: rtl/kmap_vector_counter.sv
// Settle timer plus 4-bit vector index; the index doubles as the registered DUT stimulus.
module kmap_vector_counter
  import kmap_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             settle_en,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic             settle_done,
  output logic             last
);

  localparam logic [3:0] TimerLast = 4'(SETTLE_CYCLES - 1);

  logic [3:0]       timer_q;
  logic [IDX_W-1:0] idx_q;

  assign settle_done = settle_en && (timer_q == TimerLast);
  assign last        = (idx_q == '1);
  assign idx         = idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (clear || !settle_en || settle_done) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 4'd1;
    end
  end

  // Index stops at 15; it holds between runs so the DUT inputs stay put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (advance && !last) begin
      idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/kmap_bist_checker.sv
// Exhaustive 16-vector BIST of a 4-input function against a golden truth table.
module kmap_bist_checker
  import kmap_bist_pkg::*;
#(
  parameter logic [15:0] EXPECTED      = 16'hE3AA,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  kmap_bist_checker_if.slave bus
);

  localparam logic [ERR_W-1:0] ErrMax = ERR_W'(16);

  bist_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic             settle_done, last;
  logic             cnt_clear, settle_en, advance;
  logic             accept, mismatch;
  logic [ERR_W-1:0] err_q, err_next;
  logic             busy_q, done_q, pass_q, ffv_q;
  logic [IDX_W-1:0] ffi_q;
  logic [15:0]      captured_q;

  kmap_vector_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .settle_en  (settle_en),
    .advance    (advance),
    .idx        (idx),
    .settle_done(settle_done),
    .last       (last)
  );

  assign accept   = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
  assign mismatch = (bus.dut_f != EXPECTED[idx]);
  assign err_next = (mismatch && (err_q != ErrMax)) ? err_q + 1'b1 : err_q;

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    settle_en = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          cnt_clear = 1'b1;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        settle_en = 1'b1;
        if (settle_done) state_d = StSample;
      end
      StSample: begin
        if (last) begin
          state_d = StDone;
        end else begin
          advance = 1'b1;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffv_q      <= 1'b0;
      ffi_q      <= '0;
      captured_q <= '0;
    end else if (accept) begin
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffv_q      <= 1'b0;
      ffi_q      <= '0;
      captured_q <= '0;
    end else if (state_q == StSample) begin
      captured_q[idx] <= bus.dut_f;
      err_q           <= err_next;
      if (mismatch && !ffv_q) begin
        ffv_q <= 1'b1;
        ffi_q <= idx;
      end
      // Pass uses the count including this final sample.
      if (last) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        pass_q <= (err_next == '0);
      end
    end
  end

  assign {bus.dut_p, bus.dut_q, bus.dut_r, bus.dut_s} = idx;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;
  assign bus.captured         = captured_q;

endmodule

// File: tb/tb_kmap_bist_checker.sv
// Scoreboarded bench: expected run results queued at start, compared when done rises.
module tb_kmap_bist_checker;
  import kmap_bist_pkg::*;

  localparam int unsigned SETTLE = 2;
  localparam int DONE_EDGE = 16 * (SETTLE + 1) + 1;  // accepting edge counted as edge 1

  typedef struct packed {
    logic        pass;
    logic [4:0]  err;
    logic        ffv;
    logic [3:0]  ffi;
    logic [15:0] cap;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kmap_bist_checker_if bus ();

  kmap_bist_checker #(
    .EXPECTED     (16'hE3AA),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic sop(input logic [3:0] v);
    logic p, q, r, s;
    {p, q, r, s} = v;
    return (q & s) | (!p & !r & s) | (p & q & r) | (!p & r & s) | (p & !q & !r);
  endfunction

  // 0: correct, 1: stuck-at-0, 2: inverted, 3: forced 0 at vector 14
  function automatic logic model_f(input int m, input logic [3:0] v);
    case (m)
      1:       return 1'b0;
      2:       return !sop(v);
      3:       return (v == 4'd14) ? 1'b0 : sop(v);
      default: return sop(v);
    endcase
  endfunction

  always_comb bus.dut_f = model_f(mode, {bus.dut_p, bus.dut_q, bus.dut_r, bus.dut_s});

  function automatic res_t model_run(input int m);
    res_t r;
    logic f;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      f = model_f(m, i[3:0]);
      r.cap[i] = f;
      if (f != sop(i[3:0])) begin
        if (!r.ffv) begin
          r.ffv = 1'b1;
          r.ffi = i[3:0];
        end
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (r.err == 5'd0);
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r.pass = bus.pass;
    r.err  = bus.err_count;
    r.ffv  = bus.first_fail_valid;
    r.ffi  = bus.first_fail_idx;
    r.cap  = bus.captured;
    return r;
  endfunction

  function automatic logic [3:0] vec();
    return {bus.dut_p, bus.dut_q, bus.dut_r, bus.dut_s};
  endfunction

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = bus.done;
    end
  endtask

  task automatic wait_vec(input logic [3:0] v, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = (vec() == v);
    end
  endtask

  task automatic pulse_start(input int m, output int acc);
    @(negedge clk);
    mode      = m;
    bus.start = 1'b1;
    sb.push_back(model_run(m));
    @(negedge clk);
    bus.start = 1'b0;
    acc       = cyc;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (observe() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_status got=%h want=%h", observe(), res_t'(0));
    end
    checks++;
    if ({bus.busy, bus.done, vec()} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy/done/vec got=%b want=000000", {bus.busy, bus.done, vec()});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start busy/done got=%b want=00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_patterns();
    int   acc;
    bit   ok;
    res_t exp, got;
    for (int m = 0; m < 4; m++) begin
      pulse_start(m, acc);
      wait_done(200, ok);
      checks++;
      if (!ok || (cyc - acc + 1) != DONE_EDGE) begin
        errors++;
        $display("FAIL done_edge mode%0d got=%0d (seen=%0b) want=%0d", m, cyc - acc + 1, ok,
                 DONE_EDGE);
      end
      exp = (sb.size() != 0) ? sb.pop_front() : res_t'('1);
      got = observe();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL result mode%0d got pass=%b err=%0d ffv=%b ffi=%0d cap=%h want pass=%b err=%0d ffv=%b ffi=%0d cap=%h",
                 m, got.pass, got.err, got.ffv, got.ffi, got.cap,
                 exp.pass, exp.err, exp.ffv, exp.ffi, exp.cap);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done mode%0d got=%b want=0", m, bus.busy);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int   acc;
    bit   ok;
    res_t exp, got;
    pulse_start(0, acc);
    wait_vec(4'd7, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reach_idx7 got=%0d want=7", vec());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({observe(), bus.busy, bus.done, vec()} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_async got=%h/%b%b/%0d want=0", observe(), bus.busy, bus.done,
               vec());
    end
    @(negedge clk);
    checks++;
    if ({observe(), bus.busy, bus.done, vec()} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_held got=%h/%b%b/%0d want=0", observe(), bus.busy, bus.done,
               vec());
    end
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle busy/done/pass got=%b want=000",
               {bus.busy, bus.done, bus.pass});
    end
    pulse_start(0, acc);
    wait_done(200, ok);
    checks++;
    if (!ok || (cyc - acc + 1) != DONE_EDGE) begin
      errors++;
      $display("FAIL rerun_done_edge got=%0d want=%0d", cyc - acc + 1, DONE_EDGE);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : res_t'('1);
    got = observe();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rerun_result got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_start_ignored();
    int   acc;
    bit   ok;
    res_t exp, got;
    pulse_start(0, acc);
    wait_vec(4'd3, 100, ok);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok || (cyc - acc + 1) != DONE_EDGE) begin
      errors++;
      $display("FAIL busy_start_timing got=%0d want=%0d", cyc - acc + 1, DONE_EDGE);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : res_t'('1);
    got = observe();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL busy_start_result got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    int   acc;
    bit   ok;
    res_t exp, got;
    @(negedge clk);
    mode      = 0;
    bus.start = 1'b1;
    sb.push_back(model_run(0));
    sb.push_back(model_run(0));
    @(negedge clk);
    acc = cyc;
    wait_done(200, ok);
    checks++;
    if (!ok || (cyc - acc + 1) != DONE_EDGE) begin
      errors++;
      $display("FAIL b2b_first_edge got=%0d want=%0d", cyc - acc + 1, DONE_EDGE);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : res_t'('1);
    got = observe();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_first_result got=%h want=%h", got, exp);
    end
    @(negedge clk);
    acc       = cyc;
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.busy, bus.captured} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL b2b_restart done/busy/cap got=%b/%b/%h want=0/1/0000", bus.done, bus.busy,
               bus.captured);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || (cyc - acc + 1) != DONE_EDGE) begin
      errors++;
      $display("FAIL b2b_second_edge got=%0d want=%0d", cyc - acc + 1, DONE_EDGE);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : res_t'('1);
    got = observe();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_second_result got=%h want=%h", got, exp);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_patterns();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
